// File: rtl/delay_sram_ctrl.sv
// Purpose: sequences one write then one delayed read per audio sample on an external single-port SRAM.
// Latency: delayed_valid pulses 5+2*WAIT_CYCLES cycles after an accepted sample_strobe.
// Backpressure: none; a strobe seen while busy is dropped and latches the sticky overrun flag.
module delay_sram_ctrl #(
  parameter int BUF_DEPTH   = 20000,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        sample_strobe,
  input  logic [15:0] in_frame,
  input  logic [19:0] delay_len,
  output logic [15:0] delayed_frame,
  output logic        delayed_valid,
  output logic        busy,
  output logic        overrun,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_SETUP = 3'd1;
  localparam logic [2:0] S_WR_PULSE = 3'd2;
  localparam logic [2:0] S_WR_HOLD  = 3'd3;
  localparam logic [2:0] S_RD_TURN  = 3'd4;
  localparam logic [2:0] S_RD_WAIT  = 3'd5;
  localparam logic [2:0] S_RD_LATCH = 3'd6;

  // Wait counter runs 0..WAIT_CYCLES-1 inside WR_PULSE and RD_WAIT.
  localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  // Pointer arithmetic is done in 21 bits so BUF_DEPTH = 2^20 and the
  // wrap-around subtraction never go negative.
  localparam logic [20:0] DEPTH21   = 21'(BUF_DEPTH);
  localparam logic [20:0] DL_MAX    = 21'(BUF_DEPTH - 1);
  localparam logic [19:0] WPTR_LAST = 20'(BUF_DEPTH - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [19:0]      wptr;
  logic [19:0]      rptr;
  logic [20:0]      dl_q;
  logic [20:0]      fill;
  logic [15:0]      wdat;
  logic             dq_oe;
  logic [20:0]      dl_calc;
  logic [19:0]      rptr_calc;
  logic             accept;

  assign accept = (state == S_IDLE) && sample_strobe;

  // Data bus is driven only while the write phase owns it.
  assign SRAM_DQ = dq_oe ? wdat : 16'bz;

  // Clamp the requested delay into 1..BUF_DEPTH-1 so the read never hits the slot being written.
  always_comb begin
    dl_calc = {1'b0, delay_len};
    if (delay_len == 20'd0) begin
      dl_calc = 21'd1;
    end else if ({1'b0, delay_len} > DL_MAX) begin
      dl_calc = DL_MAX;
    end
  end

  // Read pointer is the write pointer stepped back by the clamped delay, modulo the buffer size.
  always_comb begin
    rptr_calc = 20'(({1'b0, wptr} >= dl_calc) ? ({1'b0, wptr} - dl_calc)
                                              : ({1'b0, wptr} + DEPTH21 - dl_calc));
  end

  // Next-state sequencing: fixed write phase followed by fixed read phase.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (sample_strobe) state_nxt = S_WR_SETUP;
      S_WR_SETUP: state_nxt = S_WR_PULSE;
      S_WR_PULSE: if (cnt == CNT_LAST) state_nxt = S_WR_HOLD;
      S_WR_HOLD:  state_nxt = S_RD_TURN;
      S_RD_TURN:  state_nxt = S_RD_WAIT;
      S_RD_WAIT:  if (cnt == CNT_LAST) state_nxt = S_RD_LATCH;
      S_RD_LATCH: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State register and the wait counter, which restarts on every state change.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == state) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // Sample capture on acceptance, read-back capture, pointer/fill advance and overrun tracking.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr          <= '0;
      rptr          <= '0;
      dl_q          <= 21'd1;
      fill          <= '0;
      wdat          <= '0;
      delayed_frame <= '0;
      delayed_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      delayed_valid <= 1'b0;
      if (accept) begin
        wdat <= in_frame;
        dl_q <= dl_calc;
        rptr <= rptr_calc;
      end
      if (sample_strobe && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      if (state == S_RD_LATCH) begin
        // Slots not yet written since reset read back as silence.
        delayed_frame <= (fill >= dl_q) ? SRAM_DQ : 16'h0000;
        delayed_valid <= 1'b1;
        wptr          <= (wptr == WPTR_LAST) ? 20'd0 : (wptr + 20'd1);
        if (fill != DEPTH21) begin
          fill <= fill + 21'd1;
        end
      end
    end
  end

  // SRAM pins are registered from the next state so they change cleanly on the clock edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy      <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      dq_oe     <= 1'b0;
    end else begin
      busy      <= (state_nxt != S_IDLE);
      SRAM_CE_N <= (state_nxt == S_IDLE);
      SRAM_UB_N <= (state_nxt == S_IDLE);
      SRAM_LB_N <= (state_nxt == S_IDLE);
      SRAM_WE_N <= (state_nxt != S_WR_PULSE);
      SRAM_OE_N <= !((state_nxt == S_RD_WAIT) || (state_nxt == S_RD_LATCH));
      dq_oe     <= (state_nxt == S_WR_SETUP) || (state_nxt == S_WR_PULSE) ||
                   (state_nxt == S_WR_HOLD);
      if (state_nxt == S_WR_SETUP) begin
        SRAM_ADDR <= wptr;
      end else if (state_nxt == S_RD_TURN) begin
        SRAM_ADDR <= rptr;
      end
    end
  end

endmodule

// File: tb/tb_delay_sram_ctrl.sv
// Bench for delay_sram_ctrl: two instances (deep/W=2 and 8-deep/W=1) share one stimulus stream.
// Each instance has its own SRAM model and its own sample-level reference model.
// Outputs are compared every cycle at the falling edge, plus hand-computed spot checks.
module tb_delay_sram_ctrl;

  localparam int DEP_A = 20000;
  localparam int W_A   = 2;
  localparam int DEP_B = 8;
  localparam int W_B   = 1;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        sample_strobe;
  logic [15:0] in_frame;
  logic [19:0] delay_len;

  logic        dv [2];
  logic        bz [2];
  logic        ov [2];
  logic        ce [2];
  logic        oe [2];
  logic        we [2];
  logic        ub [2];
  logic        lb [2];
  logic [15:0] df [2];
  logic [19:0] ad [2];
  wire  [15:0] dq_a;
  wire  [15:0] dq_b;

  delay_sram_ctrl #(.BUF_DEPTH(DEP_A), .WAIT_CYCLES(W_A)) dut_a (
    .CLK(CLK), .RESET(RESET), .sample_strobe(sample_strobe), .in_frame(in_frame),
    .delay_len(delay_len), .delayed_frame(df[0]), .delayed_valid(dv[0]), .busy(bz[0]),
    .overrun(ov[0]), .SRAM_ADDR(ad[0]), .SRAM_DQ(dq_a), .SRAM_CE_N(ce[0]),
    .SRAM_OE_N(oe[0]), .SRAM_WE_N(we[0]), .SRAM_UB_N(ub[0]), .SRAM_LB_N(lb[0]));

  delay_sram_ctrl #(.BUF_DEPTH(DEP_B), .WAIT_CYCLES(W_B)) dut_b (
    .CLK(CLK), .RESET(RESET), .sample_strobe(sample_strobe), .in_frame(in_frame),
    .delay_len(delay_len), .delayed_frame(df[1]), .delayed_valid(dv[1]), .busy(bz[1]),
    .overrun(ov[1]), .SRAM_ADDR(ad[1]), .SRAM_DQ(dq_b), .SRAM_CE_N(ce[1]),
    .SRAM_OE_N(oe[1]), .SRAM_WE_N(we[1]), .SRAM_UB_N(ub[1]), .SRAM_LB_N(lb[1]));

  always #5 CLK = ~CLK;

  // External SRAM models: asynchronous read while CE/OE low, write sampled while WE low.
  logic [15:0] sram_a [DEP_A];
  logic [15:0] sram_b [DEP_B];
  assign dq_a = (!ce[0] && !oe[0]) ? sram_a[int'(ad[0]) % DEP_A] : 16'bz;
  assign dq_b = (!ce[1] && !oe[1]) ? sram_b[int'(ad[1]) % DEP_B] : 16'bz;
  always @(posedge CLK) begin
    if (!ce[0] && !we[0]) sram_a[int'(ad[0]) % DEP_A] <= dq_a;
    if (!ce[1] && !we[1]) sram_b[int'(ad[1]) % DEP_B] <= dq_b;
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state, one slot per instance.
  int          dep [2] = '{DEP_A, DEP_B};
  int          wc  [2] = '{W_A, W_B};
  int          t_acc [2];
  int          pend_cyc [2];
  logic [15:0] pend_val [2];
  logic [15:0] last [2];
  int          wp [2];
  int          fill [2];
  bit          ovr [2];
  int          wacc [2];
  int          racc [2];
  logic [15:0] wdat [2];
  logic [15:0] mm0 [DEP_A];
  logic [15:0] mm1 [DEP_B];
  int          m_t, m_dl, m_rp;
  logic [15:0] m_rv;

  // Sample-level model: a strobe in cycle t is taken if the previous one is at least 5+2W cycles old.
  initial forever begin
    @(posedge CLK);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (RESET) begin
        t_acc[d] = -1000; pend_cyc[d] = -1; last[d] = 16'h0;
        wp[d] = 0; fill[d] = 0; ovr[d] = 1'b0;
      end else begin
        if (cyc == pend_cyc[d]) last[d] = pend_val[d];
        if (sample_strobe) begin
          m_t = cyc - 1;
          if (m_t - t_acc[d] >= 5 + 2 * wc[d]) begin
            if (delay_len == 20'd0) m_dl = 1;
            else if (int'(delay_len) > dep[d] - 1) m_dl = dep[d] - 1;
            else m_dl = int'(delay_len);
            m_rp = (wp[d] + dep[d] - m_dl) % dep[d];
            m_rv = (d == 0) ? mm0[m_rp] : mm1[m_rp];
            pend_val[d] = (fill[d] >= m_dl) ? m_rv : 16'h0;
            pend_cyc[d] = m_t + 5 + 2 * wc[d];
            t_acc[d] = m_t;
            wacc[d] = wp[d];
            racc[d] = m_rp;
            wdat[d] = in_frame;
            if (d == 0) mm0[wp[d]] = in_frame; else mm1[wp[d]] = in_frame;
            wp[d] = (wp[d] + 1) % dep[d];
            fill[d] = (fill[d] + 1 > dep[d]) ? dep[d] : fill[d] + 1;
          end else begin
            ovr[d] = 1'b1;
          end
        end
      end
    end
  end

  logic [19:0] obs_waddr [2];
  logic [19:0] obs_raddr [2];
  int          r;
  int          w;
  bit          e_busy, e_we, e_oe;

  // Cycle-by-cycle comparison of every output against the model's timeline.
  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        r = cyc - t_acc[d];
        w = wc[d];
        e_busy = (r >= 1) && (r <= 4 + 2 * w);
        e_we   = (r >= 2) && (r <= 1 + w);
        e_oe   = (r >= 4 + w) && (r <= 4 + 2 * w);
        chk($sformatf("busy%0d", d), bz[d], e_busy);
        chk($sformatf("ce_n%0d", d), ce[d], !e_busy);
        chk($sformatf("ub_n%0d", d), ub[d], !e_busy);
        chk($sformatf("lb_n%0d", d), lb[d], !e_busy);
        chk($sformatf("we_n%0d", d), we[d], !e_we);
        chk($sformatf("oe_n%0d", d), oe[d], !e_oe);
        chk($sformatf("we_oe_excl%0d", d), (we[d] || oe[d]), 1);
        chk($sformatf("valid%0d", d), dv[d], (cyc == pend_cyc[d]));
        chk($sformatf("frame%0d", d), df[d], last[d]);
        chk($sformatf("overrun%0d", d), ov[d], ovr[d]);
        if (r >= 1 && r <= 2 + w) begin
          chk($sformatf("wr_addr%0d", d), ad[d], wacc[d]);
          chk($sformatf("wr_dq%0d", d), (d == 0) ? dq_a : dq_b, wdat[d]);
        end
        if (r >= 3 + w && r <= 4 + 2 * w) begin
          chk($sformatf("rd_addr%0d", d), ad[d], racc[d]);
        end
        if (!we[d]) obs_waddr[d] = ad[d];
        if (!oe[d]) obs_raddr[d] = ad[d];
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  // Strobe once, check instance b's output 7 cycles later and instance a's 9 cycles later.
  task automatic send(input logic [15:0] f, input bit ca, input logic [15:0] ea,
                      input bit cb, input logic [15:0] eb, input int gap);
    sample_strobe = 1'b1;
    in_frame      = f;
    tick();
    sample_strobe = 1'b0;
    repeat (5) tick();
    tick();
    if (cb) begin
      chk("b_valid_at_7", dv[1], 1);
      chk("b_out", df[1], eb);
    end
    repeat (2) tick();
    if (ca) begin
      chk("a_valid_at_9", dv[0], 1);
      chk("a_out", df[0], ea);
    end
    repeat (gap) tick();
  endtask

  logic [15:0] exp_v;

  initial begin
    RESET = 1'b1;
    sample_strobe = 1'b0;
    in_frame = 16'h0;
    delay_len = 20'd3;
    tick();
    chk_en = 1'b1;
    tick();
    RESET = 1'b0;
    // Reset values.
    chk("rst_busy", bz[0], 0);
    chk("rst_overrun", ov[0], 0);
    chk("rst_valid", dv[0], 0);
    chk("rst_frame", df[0], 0);
    chk("rst_addr", ad[0], 0);
    chk("rst_ce_n", ce[0], 1);
    chk("rst_we_n", we[0], 1);
    chk("rst_oe_n", oe[0], 1);
    chk("rst_ub_n", ub[1], 1);

    // Basic delay of 3: outputs 0,0,0,1,2,3,4,5, strobes 20 cycles apart.
    for (int i = 0; i < 8; i++) begin
      exp_v = (i >= 3) ? 16'(i - 2) : 16'h0;
      send(16'(i + 1), 1'b1, exp_v, 1'b1, exp_v, 11);
    end

    // Overrun: second strobe 4 cycles into the first is dropped.
    sample_strobe = 1'b1; in_frame = 16'd9;
    tick();
    sample_strobe = 1'b0;
    repeat (3) tick();
    sample_strobe = 1'b1; in_frame = 16'hBEEF;
    tick();
    sample_strobe = 1'b0;
    chk("overrun_a_set", ov[0], 1);
    chk("overrun_b_set", ov[1], 1);
    repeat (2) tick();
    chk("ovr_b_first_out", df[1], 16'd6);
    repeat (2) tick();
    chk("ovr_a_first_out", df[0], 16'd6);
    repeat (4) tick();
    send(16'd10, 1'b1, 16'd7, 1'b1, 16'd7, 2);
    send(16'd11, 1'b1, 16'd8, 1'b1, 16'd8, 2);
    send(16'd12, 1'b1, 16'd9, 1'b1, 16'd9, 2);
    chk("overrun_a_sticky", ov[0], 1);
    chk("overrun_b_sticky", ov[1], 1);

    // Wrap-around on the 8-deep buffer with delay 5.
    do_reset();
    delay_len = 20'd5;
    for (int n = 0; n < 20; n++) begin
      exp_v = (n >= 5) ? 16'(100 + n - 5) : 16'h0;
      send(16'(100 + n), 1'b1, exp_v, 1'b1, exp_v, $urandom_range(0, 4));
      if (n % 8 == 2) begin
        chk("wrap_waddr_b", obs_waddr[1], 2);
        chk("wrap_raddr_b", obs_raddr[1], 5);
      end
    end

    // Clamping: zero behaves as one.
    do_reset();
    delay_len = 20'd0;
    for (int i = 0; i < 4; i++) begin
      send(16'(i + 1), 1'b1, 16'(i), 1'b1, 16'(i), 1);
    end
    // Clamping: huge value behaves as depth-1.
    do_reset();
    delay_len = 20'hFFFFF;
    for (int i = 0; i < 10; i++) begin
      exp_v = (i >= 7) ? 16'(i - 6) : 16'h0;
      send(16'(i + 1), 1'b1, 16'h0, 1'b1, exp_v, 1);
    end

    // Reset in the middle of the write pulse.
    delay_len = 20'd1;
    sample_strobe = 1'b1; in_frame = 16'h0055;
    tick();
    sample_strobe = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("midrst_we_n_a", we[0], 1);
    chk("midrst_ce_n_a", ce[0], 1);
    chk("midrst_busy_a", bz[0], 0);
    chk("midrst_we_n_b", we[1], 1);
    chk("midrst_busy_b", bz[1], 0);
    send(16'h0077, 1'b1, 16'h0, 1'b1, 16'h0, 2);
    chk("midrst_wptr_a", obs_waddr[0], 0);
    chk("midrst_wptr_b", obs_waddr[1], 0);
    send(16'h0078, 1'b1, 16'h0077, 1'b1, 16'h0077, 2);

    // Randomized traffic: mixed delays, tight and loose spacing, occasional reset.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 29) == 0) do_reset();
      case ($urandom_range(0, 3))
        0:       delay_len = 20'd0;
        1:       delay_len = 20'($urandom_range(1, 10));
        2:       delay_len = 20'($urandom_range(1, 25000));
        default: delay_len = 20'hFFFFF;
      endcase
      in_frame = 16'($urandom);
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      repeat ($urandom_range(2, 24)) tick();
    end

    repeat (30) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
